ysyx_22040895_mdu: RTL and testbench

YSYX_22040895_MDU -- requirements
Module: ysyx_22040895_mdu

---
 rtl/ysyx_22040895_mdu_pkg.sv | 37 +++
 rtl/ysyx_22040895_mdu.sv | 238 +++++++++++++++++++++++
 tb/tb_ysyx_22040895_mdu.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040895_mdu_pkg.sv
// Shared encodings for the execute-stage units.
// ALU and MDU op codes, MDU FSM states, iteration constants.
package ysyx_22040895_mdu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  localparam int MDU_WORD_ITERS = 32;

endpackage

// File: rtl/ysyx_22040895_mdu.sv
// Iterative multiply/divide unit, one bit per cycle.
// Shift-add multiply and restoring divide on magnitudes.
module ysyx_22040895_mdu
  import ysyx_22040895_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i_mdu,
  output logic            ready_o_mdu,
  input  logic [2:0]      mduop_i_mdu,
  input  logic            word_i_mdu,
  input  logic [XLEN-1:0] op1_i_mdu,
  input  logic [XLEN-1:0] op2_i_mdu,
  input  logic            flush_i_mdu,
  output logic            valid_o_mdu,
  input  logic            ready_i_mdu,
  output logic [XLEN-1:0] result_o_mdu
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_D = CW'(XLEN-1);
  localparam logic [CW-1:0] LAST_W = CW'(MDU_WORD_ITERS-1);
  localparam logic [XLEN-1:0] MIN_D =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W =
    {{(XLEN-31){1'b1}}, {31{1'b0}}};

  function automatic logic [XLEN-1:0] sext32(
    input logic [31:0] v
  );
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(
    input logic [31:0] v
  );
    return {{(XLEN-32){1'b0}}, v};
  endfunction

  mdu_state_e      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            word_q;
  logic            neg_q;
  logic            rneg_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;

  logic            s1;
  logic            s2;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            is_div;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] hi_n;
  logic [XLEN-1:0] lo_n;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] q_s;
  logic [XLEN-1:0] r_s;
  logic [XLEN-1:0] sel;
  logic [XLEN-1:0] fin;

  // Operand signedness from the incoming op
  always_comb begin
    s1 = 1'b0;
    s2 = 1'b0;
    unique case (1'b1)
      (mduop_i_mdu == MDU_MULH),
      (mduop_i_mdu == MDU_DIV),
      (mduop_i_mdu == MDU_REM): begin
        s1 = 1'b1;
        s2 = 1'b1;
      end
      (mduop_i_mdu == MDU_MULHSU): s1 = 1'b1;
      default: ;
    endcase
  end

  // Width-adjusted operands and early-out detection
  always_comb begin
    a_ext = op1_i_mdu;
    b_ext = op2_i_mdu;
    if (word_i_mdu) begin
      a_ext = s1 ? sext32(op1_i_mdu[31:0])
                 : zext32(op1_i_mdu[31:0]);
      b_ext = s2 ? sext32(op2_i_mdu[31:0])
                 : zext32(op2_i_mdu[31:0]);
    end
    a_neg = s1 & a_ext[XLEN-1];
    b_neg = s2 & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    is_div = mduop_i_mdu[2];
    div_zero = is_div & (b_ext == '0);
    div_ovf = is_div & ~mduop_i_mdu[0]
            & (a_ext == (word_i_mdu ? MIN_W : MIN_D))
            & (b_ext == '1);
    spec_res = '0;
    if (div_zero) begin
      if (!mduop_i_mdu[1])
        spec_res = '1;
      else if (word_i_mdu)
        spec_res = sext32(op1_i_mdu[31:0]);
      else
        spec_res = op1_i_mdu;
    end else if (!mduop_i_mdu[1]) begin
      spec_res = a_ext;
    end
  end

  assign sum = {1'b0, hi_q}
             + {1'b0, {XLEN{lo_q[0]}} & b_q};
  assign shifted = {hi_q, lo_q[XLEN-1]};
  assign diff = shifted - {1'b0, b_q};

  // One iteration of shift-add or restoring divide
  always_comb begin
    if (op_q[2]) begin
      if (diff[XLEN]) begin
        hi_n = shifted[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end else begin
        hi_n = diff[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection after the last step
  always_comb begin
    prod_s = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    q_s = neg_q ? -lo_n : lo_n;
    r_s = rneg_q ? -hi_n : hi_n;
    sel = op_q[1] ? r_s : q_s;
    if (op_q[2])
      fin = word_q ? sext32(sel[31:0]) : sel;
    else if (word_q)
      fin = sext32(lo_n[XLEN-1:XLEN-32]);
    else if (op_q == MDU_MUL)
      fin = prod_s[XLEN-1:0];
    else
      fin = prod_s[2*XLEN-1:XLEN];
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= MDU_IDLE;
      ready_o_mdu  <= 1'b1;
      valid_o_mdu  <= 1'b0;
      result_o_mdu <= '0;
      cnt          <= '0;
      op_q         <= '0;
      word_q       <= 1'b0;
      neg_q        <= 1'b0;
      rneg_q       <= 1'b0;
      b_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else if (flush_i_mdu) begin
      state       <= MDU_IDLE;
      ready_o_mdu <= 1'b1;
      valid_o_mdu <= 1'b0;
      cnt         <= '0;
    end else begin
      unique case (state)
        MDU_IDLE: begin
          if (valid_i_mdu) begin
            op_q        <= mduop_i_mdu;
            word_q      <= word_i_mdu;
            neg_q       <= a_neg ^ b_neg;
            rneg_q      <= a_neg;
            cnt         <= '0;
            ready_o_mdu <= 1'b0;
            if (div_zero || div_ovf) begin
              state        <= MDU_DONE;
              valid_o_mdu  <= 1'b1;
              result_o_mdu <= spec_res;
            end else begin
              state <= MDU_BUSY;
              hi_q  <= '0;
              if (is_div) begin
                b_q  <= b_mag;
                lo_q <= word_i_mdu
                      ? (a_mag << (XLEN-32))
                      : a_mag;
              end else begin
                b_q  <= a_mag;
                lo_q <= b_mag;
              end
            end
          end
        end
        MDU_BUSY: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          if (cnt == (word_q ? LAST_W : LAST_D)) begin
            state        <= MDU_DONE;
            valid_o_mdu  <= 1'b1;
            result_o_mdu <= fin;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MDU_DONE: begin
          if (ready_i_mdu) begin
            state       <= MDU_IDLE;
            valid_o_mdu <= 1'b0;
            ready_o_mdu <= 1'b1;
          end
        end
        default: begin
          state       <= MDU_IDLE;
          ready_o_mdu <= 1'b1;
          valid_o_mdu <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_mdu.sv
// Directed and random checks of the iterative MDU.
// Expected results come from a behavioural reference.
module tb_ysyx_22040895_mdu;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  mduop;
  logic        word;
  logic [63:0] op1;
  logic [63:0] op2;
  logic        flush;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] result;

  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];

  ysyx_22040895_mdu #(.XLEN(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i_mdu  (valid_i),
    .ready_o_mdu  (ready_o),
    .mduop_i_mdu  (mduop),
    .word_i_mdu   (word),
    .op1_i_mdu    (op1),
    .op2_i_mdu    (op2),
    .flush_i_mdu  (flush),
    .valid_o_mdu  (valid_o),
    .ready_i_mdu  (ready_i),
    .result_o_mdu (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mdu(
    input logic [2:0] op, input logic w,
    input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic signed [31:0] a32;
    logic signed [31:0] b32;
    logic [31:0] r32;
    logic [63:0] r;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = '0;
    r = '0;
    if (w) begin
      case (op)
        3'd0: r32 = a[31:0] * b[31:0];
        3'd4: begin
          if (b32 == 0) r32 = 32'hFFFF_FFFF;
          else if (a32 == 32'sh8000_0000 && b32 == -1)
            r32 = a32;
          else r32 = a32 / b32;
        end
        3'd5: begin
          if (b[31:0] == 0) r32 = 32'hFFFF_FFFF;
          else r32 = a[31:0] / b[31:0];
        end
        3'd6: begin
          if (b32 == 0) r32 = a32;
          else if (a32 == 32'sh8000_0000 && b32 == -1)
            r32 = 0;
          else r32 = a32 % b32;
        end
        3'd7: begin
          if (b[31:0] == 0) r32 = a[31:0];
          else r32 = a[31:0] % b[31:0];
        end
        default: r32 = '0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (op)
      3'd0: r = a * b;
      3'd1: begin
        p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        r = p[127:64];
      end
      3'd2: begin
        p = {{64{a[63]}}, a} * {64'd0, b};
        r = p[127:64];
      end
      3'd3: begin
        p = {64'd0, a} * {64'd0, b};
        r = p[127:64];
      end
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1)
          r = a;
        else r = $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) r = '1;
        else r = a / b;
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1)
          r = 0;
        else r = $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic int busy_of(
    input logic [2:0] op, input logic w,
    input logic [63:0] a, input logic [63:0] b);
    logic z;
    logic o;
    if (!op[2]) return w ? 32 : 64;
    z = w ? (b[31:0] == 0) : (b == 0);
    o = !op[0] && (w
        ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
        : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (z || o) return 0;
    return w ? 32 : 64;
  endfunction

  task automatic run(input string tag,
                     input logic [2:0] op, input logic w,
                     input logic [63:0] a,
                     input logic [63:0] b,
                     input logic [63:0] exp,
                     input int busy);
    int n;
    logic [63:0] e;
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(ready_o), 64'd1);
    valid_i = 1'b1;
    mduop = op;
    word = w;
    op1 = a;
    op2 = b;
    @(posedge clk);
    sb.push_back(exp);
    #1;
    valid_i = 1'b0;
    mduop = ~op;
    word = ~w;
    op1 = ~a;
    op2 = ~b;
    n = 0;
    while (valid_o !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(busy));
    e = sb.pop_front();
    chk(tag, result, e);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_hold"}, {63'd0, valid_o}, 64'd1);
    chk({tag, "_stable"}, result, e);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    chk({tag, "_idle"}, {62'd0, valid_o, ready_o}, 64'd1);
  endtask

  task automatic watch_quiet(input string tag,
                             input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (valid_o === 1'b1) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic        rw;
    logic [63:0] ra;
    logic [63:0] rb;
    rst_n = 1'b1;
    valid_i = 1'b0;
    mduop = '0;
    word = 1'b0;
    op1 = '0;
    op2 = '0;
    flush = 1'b0;
    ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", result, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run("mul", 3'b000, 1'b0, 64'd7, -64'sd3,
        64'hFFFF_FFFF_FFFF_FFEB, 64);
    run("mulhu", 3'b011, 1'b0, '1, '1,
        64'hFFFF_FFFF_FFFF_FFFE, 64);
    run("mulh", 3'b001, 1'b0, '1, '1, 64'd0, 64);
    run("div", 3'b100, 1'b0, -64'sd7, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, 64);
    run("rem", 3'b110, 1'b0, -64'sd7, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFF, 64);
    run("divuw", 3'b101, 1'b1, 64'h8000_0000, 64'd1,
        64'hFFFF_FFFF_8000_0000, 32);
    run("div0", 3'b100, 1'b0, 64'h1234, 64'd0,
        64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("rem0", 3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 0);
    run("divovf", 3'b100, 1'b0,
        64'h8000_0000_0000_0000, '1,
        64'h8000_0000_0000_0000, 0);
    run("removfw", 3'b110, 1'b1,
        64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 0);
    run("remuw0", 3'b111, 1'b1, 64'h8000_0001,
        64'hABCD_0000_0000, 64'hFFFF_FFFF_8000_0001, 0);
    run("mulw", 3'b000, 1'b1, 64'h7FFF_FFFF,
        64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32);

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
      rw = (rop == 3'd0 || rop[2])
         ? 1'($urandom_range(0, 1)) : 1'b0;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 3 == 0) rb = 64'($urandom_range(1, 9));
      if (i % 4 == 1) rb = -rb;
      run($sformatf("rnd%0d_op%0d_w%0d", i, rop, rw),
          rop, rw, ra, rb,
          ref_mdu(rop, rw, ra, rb),
          busy_of(rop, rw, ra, rb));
    end

    @(negedge clk);
    valid_i = 1'b1;
    mduop = 3'b000;
    word = 1'b0;
    op1 = 64'd11;
    op2 = 64'd13;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_ready", 64'(ready_o), 64'd1);
    chk("flush_valid", 64'(valid_o), 64'd0);
    watch_quiet("flush_quiet", 80);
    run("post_flush", 3'b110, 1'b0, 64'd100, 64'd7,
        64'd2, 64);

    @(negedge clk);
    valid_i = 1'b1;
    flush = 1'b1;
    mduop = 3'b100;
    op1 = 64'd9;
    op2 = 64'd0;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    flush = 1'b0;
    chk("flush_accept_ready", 64'(ready_o), 64'd1);
    watch_quiet("flush_accept_quiet", 5);

    @(negedge clk);
    valid_i = 1'b1;
    mduop = 3'b101;
    op1 = 64'd1000;
    op2 = 64'd3;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(ready_o), 64'd1);
    watch_quiet("post_rst_quiet", 80);
    run("post_rst", 3'b010, 1'b0, '1, 64'd2, '1, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
